// File: rtl/reg_read_pkg.sv
// Shared constants, field layout and helpers for the register read stage.
// Packets are indexed by the LSB constants below; the branch mask sits in the top bits.
package reg_read_pkg;
    localparam int ISSUE_WIDTH  = 4;
    localparam int PACKET_W     = 128;
    localparam int PHYS_LOG     = 7;
    localparam int DATA_W       = 32;
    localparam int CHECKPOINTS  = 8;
    localparam int CKPT_LOG     = $clog2(CHECKPOINTS);
    localparam int BYPASS_PORTS = 4;

    localparam int MASK_LSB     = PACKET_W - CHECKPOINTS;
    localparam int MASK_W       = CHECKPOINTS;
    localparam int SRC1_LSB     = 40;
    localparam int SRC2_LSB     = 47;
    localparam int DEST_LSB     = 33;
    localparam int OPCODE_LSB   = 0;
    localparam int OPCODE_W     = 8;

    typedef logic [CHECKPOINTS-1:0] mask_t;
    typedef logic [PHYS_LOG-1:0]    tag_t;
    typedef logic [DATA_W-1:0]      data_t;

    function automatic mask_t mask_clear(input mask_t mask, input logic [CKPT_LOG-1:0] id);
        mask_t m;
        m     = mask;
        m[id] = 1'b0;
        return m;
    endfunction
endpackage

// File: rtl/reg_read_stage_operand_bypass_mux.sv
// Per-source operand select: the lowest-numbered writeback port whose tag matches
// wins over the register file read data.
module operand_bypass_mux
    import reg_read_pkg::*;
(
    input  logic [PHYS_LOG-1:0]              tag,
    input  logic [DATA_W-1:0]                prf_data,
    input  logic [BYPASS_PORTS-1:0]          byp_valid,
    input  logic [BYPASS_PORTS*PHYS_LOG-1:0] byp_tag,
    input  logic [BYPASS_PORTS*DATA_W-1:0]   byp_data,
    output logic [DATA_W-1:0]                operand
);
    logic hit;

    always_comb begin
        operand = prf_data;
        hit     = 1'b0;
        for (int p = 0; p < BYPASS_PORTS; p++) begin
            if (!hit && byp_valid[p] && (byp_tag[p*PHYS_LOG +: PHYS_LOG] == tag)) begin
                operand = byp_data[p*DATA_W +: DATA_W];
                hit     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_read_stage.sv
// Register read stage: PRF address generation, bypass override, squash and
// branch-mask maintenance, and the one-cycle flop bank toward execute.
module reg_read_stage
    import reg_read_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ISSUE_WIDTH-1:0]              grantedValid_i,
    input  logic [ISSUE_WIDTH*PACKET_W-1:0]     grantedPacket_i,
    output logic [2*ISSUE_WIDTH*PHYS_LOG-1:0]   prfAddr_o,
    input  logic [2*ISSUE_WIDTH*DATA_W-1:0]     prfData_i,
    input  logic [BYPASS_PORTS-1:0]             bypValid_i,
    input  logic [BYPASS_PORTS*PHYS_LOG-1:0]    bypTag_i,
    input  logic [BYPASS_PORTS*DATA_W-1:0]      bypData_i,
    input  logic                                ctrlVerified_i,
    input  logic                                ctrlMispredict_i,
    input  logic [CKPT_LOG-1:0]                 ctrlCkpt_i,
    input  logic                                flush_i,
    output logic [ISSUE_WIDTH-1:0]              rrValid_o,
    output logic [ISSUE_WIDTH*PACKET_W-1:0]     rrPacket_o,
    output logic [ISSUE_WIDTH*DATA_W-1:0]       rrOpA_o,
    output logic [ISSUE_WIDTH*DATA_W-1:0]       rrOpB_o
);
    logic mispredict;
    logic verify_ok;

    assign mispredict = ctrlVerified_i & ctrlMispredict_i;
    assign verify_ok  = ctrlVerified_i & ~ctrlMispredict_i;

    genvar gi;
    generate
        for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
            logic [PACKET_W-1:0] pkt_in;
            logic [PHYS_LOG-1:0] src1_tag;
            logic [PHYS_LOG-1:0] src2_tag;
            logic [MASK_W-1:0]   mask_in;
            logic [MASK_W-1:0]   mask_held;
            logic [DATA_W-1:0]   op_a_sel;
            logic [DATA_W-1:0]   op_b_sel;
            logic                kill;

            logic                valid_reg;
            logic [PACKET_W-1:0] pkt_reg;
            logic [PACKET_W-1:0] pkt_next;
            logic [DATA_W-1:0]   op_a_reg;
            logic [DATA_W-1:0]   op_b_reg;

            assign pkt_in    = grantedPacket_i[gi*PACKET_W +: PACKET_W];
            assign src1_tag  = pkt_in[SRC1_LSB +: PHYS_LOG];
            assign src2_tag  = pkt_in[SRC2_LSB +: PHYS_LOG];
            assign mask_in   = pkt_in[MASK_LSB +: MASK_W];
            assign mask_held = pkt_reg[MASK_LSB +: MASK_W];

            // Addresses go out regardless of lane valid so the PRF read never waits on issue.
            assign prfAddr_o[gi*2*PHYS_LOG +: 2*PHYS_LOG] = {src2_tag, src1_tag};

            operand_bypass_mux u_byp_a (
                .tag       (src1_tag),
                .prf_data  (prfData_i[(2*gi)*DATA_W +: DATA_W]),
                .byp_valid (bypValid_i),
                .byp_tag   (bypTag_i),
                .byp_data  (bypData_i),
                .operand   (op_a_sel)
            );

            operand_bypass_mux u_byp_b (
                .tag       (src2_tag),
                .prf_data  (prfData_i[(2*gi+1)*DATA_W +: DATA_W]),
                .byp_valid (bypValid_i),
                .byp_tag   (bypTag_i),
                .byp_data  (bypData_i),
                .operand   (op_b_sel)
            );

            assign kill = flush_i | (mispredict & mask_in[ctrlCkpt_i]);

            // A correct resolution frees its checkpoint in whatever packet the lane ends up holding.
            always_comb begin
                pkt_next = pkt_reg;
                if (grantedValid_i[gi]) begin
                    pkt_next = pkt_in;
                    if (verify_ok) pkt_next[MASK_LSB +: MASK_W] = mask_clear(mask_in, ctrlCkpt_i);
                end else if (verify_ok) begin
                    pkt_next[MASK_LSB +: MASK_W] = mask_clear(mask_held, ctrlCkpt_i);
                end
            end

            // Valid never outlives the grant, so held lanes drop out on flush/mispredict for free.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                    pkt_reg   <= '0;
                    op_a_reg  <= '0;
                    op_b_reg  <= '0;
                end else begin
                    valid_reg <= grantedValid_i[gi] & ~kill;
                    pkt_reg   <= pkt_next;
                    if (grantedValid_i[gi]) begin
                        op_a_reg <= op_a_sel;
                        op_b_reg <= op_b_sel;
                    end
                end
            end

            assign rrValid_o[gi]                      = valid_reg;
            assign rrPacket_o[gi*PACKET_W +: PACKET_W] = pkt_reg;
            assign rrOpA_o[gi*DATA_W +: DATA_W]        = op_a_reg;
            assign rrOpB_o[gi*DATA_W +: DATA_W]        = op_b_reg;
        end
    endgenerate
endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage: a reference model pushes the expected
// register contents per cycle; each scenario pops and compares after the edge.
module tb_reg_read_stage;
    import reg_read_pkg::*;

    localparam int IW = ISSUE_WIDTH;

    logic                            clk = 1'b0;
    logic                            reset = 1'b0;
    logic [IW-1:0]                   grantedValid_i;
    logic [IW*PACKET_W-1:0]          grantedPacket_i;
    logic [2*IW*PHYS_LOG-1:0]        prfAddr_o;
    logic [2*IW*DATA_W-1:0]          prfData_i;
    logic [BYPASS_PORTS-1:0]         bypValid_i;
    logic [BYPASS_PORTS*PHYS_LOG-1:0] bypTag_i;
    logic [BYPASS_PORTS*DATA_W-1:0]  bypData_i;
    logic                            ctrlVerified_i;
    logic                            ctrlMispredict_i;
    logic [CKPT_LOG-1:0]             ctrlCkpt_i;
    logic                            flush_i;
    logic [IW-1:0]                   rrValid_o;
    logic [IW*PACKET_W-1:0]          rrPacket_o;
    logic [IW*DATA_W-1:0]            rrOpA_o;
    logic [IW*DATA_W-1:0]            rrOpB_o;

    always #5 clk = ~clk;

    reg_read_stage dut (
        .clk              (clk),
        .reset            (reset),
        .grantedValid_i   (grantedValid_i),
        .grantedPacket_i  (grantedPacket_i),
        .prfAddr_o        (prfAddr_o),
        .prfData_i        (prfData_i),
        .bypValid_i       (bypValid_i),
        .bypTag_i         (bypTag_i),
        .bypData_i        (bypData_i),
        .ctrlVerified_i   (ctrlVerified_i),
        .ctrlMispredict_i (ctrlMispredict_i),
        .ctrlCkpt_i       (ctrlCkpt_i),
        .flush_i          (flush_i),
        .rrValid_o        (rrValid_o),
        .rrPacket_o       (rrPacket_o),
        .rrOpA_o          (rrOpA_o),
        .rrOpB_o          (rrOpB_o)
    );

    typedef struct packed {
        logic [IW-1:0]          valid;
        logic [IW*PACKET_W-1:0] pkt;
        logic [IW*DATA_W-1:0]   a;
        logic [IW*DATA_W-1:0]   b;
    } exp_t;

    exp_t q[$];
    exp_t m;
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn      = 0;
    bit   allow_dup = 1'b0;

    // Two live bypass ports carrying the same tag is illegal outside the priority scenario.
    always @(negedge clk) begin
        if (reset && !allow_dup) begin
            for (int i = 0; i < BYPASS_PORTS; i++)
                for (int j = i + 1; j < BYPASS_PORTS; j++)
                    assert (!(bypValid_i[i] && bypValid_i[j] &&
                              bypTag_i[i*PHYS_LOG +: PHYS_LOG] == bypTag_i[j*PHYS_LOG +: PHYS_LOG]))
                    else $error("FAIL dup_bypass ports %0d and %0d share a tag", i, j);
        end
    end

    function automatic logic [DATA_W-1:0] ref_sel(input logic [PHYS_LOG-1:0] tag,
                                                  input logic [DATA_W-1:0] prf);
        logic [DATA_W-1:0] r;
        r = prf;
        for (int p = BYPASS_PORTS - 1; p >= 0; p--)
            if (bypValid_i[p] && bypTag_i[p*PHYS_LOG +: PHYS_LOG] == tag)
                r = bypData_i[p*DATA_W +: DATA_W];
        return r;
    endfunction

    function automatic logic [PACKET_W-1:0] mk_pkt(input logic [7:0] mask,
                                                  input logic [PHYS_LOG-1:0] s1,
                                                  input logic [PHYS_LOG-1:0] s2);
        logic [PACKET_W-1:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        p[MASK_LSB +: MASK_W]   = mask;
        p[SRC1_LSB +: PHYS_LOG] = s1;
        p[SRC2_LSB +: PHYS_LOG] = s2;
        return p;
    endfunction

    task automatic clear_inputs();
        grantedValid_i   = '0;
        grantedPacket_i  = '0;
        prfData_i        = '0;
        bypValid_i       = '0;
        bypTag_i         = '0;
        bypData_i        = '0;
        ctrlVerified_i   = 1'b0;
        ctrlMispredict_i = 1'b0;
        ctrlCkpt_i       = '0;
        flush_i          = 1'b0;
    endtask

    task automatic set_lane(input int k, input logic [7:0] mask,
                            input logic [PHYS_LOG-1:0] s1, input logic [PHYS_LOG-1:0] s2);
        grantedPacket_i[k*PACKET_W +: PACKET_W] = mk_pkt(mask, s1, s2);
        grantedValid_i[k] = 1'b1;
    endtask

    task automatic set_prf(input int k, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        prfData_i[(2*k)*DATA_W +: DATA_W]   = a;
        prfData_i[(2*k+1)*DATA_W +: DATA_W] = b;
    endtask

    task automatic set_byp(input int p, input logic v, input logic [PHYS_LOG-1:0] tag,
                           input logic [DATA_W-1:0] d);
        bypValid_i[p]                     = v;
        bypTag_i[p*PHYS_LOG +: PHYS_LOG]  = tag;
        bypData_i[p*DATA_W +: DATA_W]     = d;
    endtask

    // Reference model update for the current inputs, then advance one edge.
    task automatic step();
        logic [PACKET_W-1:0] p;
        logic [7:0]          mk;
        logic                kill;
        for (int k = 0; k < IW; k++) begin
            p    = grantedPacket_i[k*PACKET_W +: PACKET_W];
            mk   = p[MASK_LSB +: MASK_W];
            kill = flush_i || (ctrlVerified_i && ctrlMispredict_i && mk[ctrlCkpt_i]);
            m.valid[k] = grantedValid_i[k] && !kill;
            if (grantedValid_i[k]) begin
                m.pkt[k*PACKET_W +: PACKET_W] = p;
                m.a[k*DATA_W +: DATA_W] = ref_sel(p[SRC1_LSB +: PHYS_LOG],
                                                  prfData_i[(2*k)*DATA_W +: DATA_W]);
                m.b[k*DATA_W +: DATA_W] = ref_sel(p[SRC2_LSB +: PHYS_LOG],
                                                  prfData_i[(2*k+1)*DATA_W +: DATA_W]);
            end
            if (ctrlVerified_i && !ctrlMispredict_i)
                m.pkt[k*PACKET_W + MASK_LSB + int'(ctrlCkpt_i)] = 1'b0;
        end
        q.push_back(m);
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d: granted=%h flush=%b ver=%b mis=%b ckpt=%0d exp_valid=%h dut_valid=%h",
                 txn, grantedValid_i, flush_i, ctrlVerified_i, ctrlMispredict_i, ctrlCkpt_i,
                 m.valid, rrValid_o);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        grantedValid_i = 4'hF;
        for (int k = 0; k < IW; k++) set_lane(k, 8'hFF, 7'(k + 1), 7'(k + 2));
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (rrValid_o !== '0) begin n_fail++; $display("FAIL reset_valid got=%h want=0", rrValid_o); end
        n_checks++;
        if (rrPacket_o !== '0) begin n_fail++; $display("FAIL reset_packet got nonzero want=0"); end
        n_checks++;
        if (rrOpA_o !== '0 || rrOpB_o !== '0) begin
            n_fail++; $display("FAIL reset_operands got a=%h b=%h want=0", rrOpA_o, rrOpB_o);
        end

        @(negedge clk);
        reset = 1'b1;
        m = '0;
        clear_inputs();
        set_lane(0, 8'h00, 7'd3, 7'd4);
        step();
        e = q.pop_front();
        n_checks++;
        if (rrValid_o !== 4'h1 || rrValid_o !== e.valid) begin
            n_fail++; $display("FAIL first_lane0 valid got=%h want=1", rrValid_o);
        end
        n_checks++;
        if (rrPacket_o !== e.pkt) begin n_fail++; $display("FAIL first_lane0 packet differs from model"); end

        // Assert reset between edges with every lane in flight.
        clear_inputs();
        for (int k = 0; k < IW; k++) set_lane(k, 8'h00, 7'd1, 7'd2);
        step();
        e = q.pop_front();
        n_checks++;
        if (rrValid_o !== 4'hF || rrValid_o !== e.valid) begin
            n_fail++; $display("FAIL midstream_load valid got=%h want=f", rrValid_o);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (rrValid_o !== '0 || rrPacket_o !== '0 || rrOpA_o !== '0) begin
            n_fail++; $display("FAIL async_reset valid got=%h want=0 (or payload nonzero)", rrValid_o);
        end
        m = '0;
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
    endtask

    task automatic test_prf_path();
        clear_inputs();
        set_lane(1, 8'h00, 7'd5, 7'd9);
        set_prf(1, 32'hAAAA, 32'hBBBB);
        #1;
        n_checks++;
        if (prfAddr_o[1*2*PHYS_LOG +: 2*PHYS_LOG] !== {7'd9, 7'd5}) begin
            n_fail++;
            $display("FAIL prf_addr got=%h want=%h", prfAddr_o[1*2*PHYS_LOG +: 2*PHYS_LOG], {7'd9, 7'd5});
        end
        step();
        e = q.pop_front();
        n_checks++;
        if (rrValid_o !== 4'b0010 || rrValid_o !== e.valid) begin
            n_fail++; $display("FAIL prf_valid got=%h want=2", rrValid_o);
        end
        n_checks++;
        if (rrOpA_o[1*DATA_W +: DATA_W] !== 32'hAAAA || rrOpA_o !== e.a) begin
            n_fail++; $display("FAIL prf_opa got=%h want=0000aaaa", rrOpA_o[1*DATA_W +: DATA_W]);
        end
        n_checks++;
        if (rrOpB_o[1*DATA_W +: DATA_W] !== 32'hBBBB || rrOpB_o !== e.b) begin
            n_fail++; $display("FAIL prf_opb got=%h want=0000bbbb", rrOpB_o[1*DATA_W +: DATA_W]);
        end
    endtask

    task automatic test_bypass();
        clear_inputs();
        allow_dup = 1'b1;
        set_lane(2, 8'h00, 7'd12, 7'd30);
        set_prf(2, 32'h1111, 32'h2222);
        set_byp(3, 1'b1, 7'd12, 32'hCAFE);
        set_byp(1, 1'b1, 7'd12, 32'hBEEF);
        step();
        e = q.pop_front();
        n_checks++;
        if (rrOpA_o[2*DATA_W +: DATA_W] !== 32'hBEEF || rrOpA_o !== e.a) begin
            n_fail++; $display("FAIL bypass_lowest got=%h want=0000beef", rrOpA_o[2*DATA_W +: DATA_W]);
        end
        n_checks++;
        if (rrOpB_o[2*DATA_W +: DATA_W] !== 32'h2222 || rrOpB_o !== e.b) begin
            n_fail++; $display("FAIL bypass_miss got=%h want=00002222", rrOpB_o[2*DATA_W +: DATA_W]);
        end
        allow_dup = 1'b0;
        set_byp(1, 1'b1, 7'd13, 32'hBEEF);
        step();
        e = q.pop_front();
        n_checks++;
        if (rrOpA_o[2*DATA_W +: DATA_W] !== 32'hCAFE || rrOpA_o !== e.a) begin
            n_fail++; $display("FAIL bypass_port3 got=%h want=0000cafe", rrOpA_o[2*DATA_W +: DATA_W]);
        end
        // Tag 0 is an ordinary tag for bypass purposes.
        clear_inputs();
        set_lane(0, 8'h00, 7'd0, 7'd0);
        set_prf(0, 32'h5, 32'h6);
        set_byp(2, 1'b1, 7'd0, 32'h0000D00D);
        step();
        e = q.pop_front();
        n_checks++;
        if (rrOpA_o[DATA_W-1:0] !== 32'hD00D || rrOpB_o[DATA_W-1:0] !== 32'hD00D || rrOpA_o !== e.a) begin
            n_fail++; $display("FAIL bypass_tag0 got a=%h b=%h want=0000d00d",
                               rrOpA_o[DATA_W-1:0], rrOpB_o[DATA_W-1:0]);
        end
    endtask

    task automatic test_mispredict();
        clear_inputs();
        set_lane(0, 8'h04, 7'd1, 7'd2);
        set_lane(3, 8'h01, 7'd3, 7'd4);
        ctrlVerified_i = 1'b1; ctrlMispredict_i = 1'b1; ctrlCkpt_i = 3'd2;
        step();
        e = q.pop_front();
        n_checks++;
        if (rrValid_o !== 4'b1000 || rrValid_o !== e.valid) begin
            n_fail++; $display("FAIL mispredict_valid got=%b want=1000", rrValid_o);
        end
        n_checks++;
        if (rrPacket_o[3*PACKET_W + MASK_LSB +: MASK_W] !== 8'h01 || rrPacket_o !== e.pkt) begin
            n_fail++; $display("FAIL mispredict_mask got=%h want=01",
                               rrPacket_o[3*PACKET_W + MASK_LSB +: MASK_W]);
        end
    endtask

    task automatic test_correct_verify();
        clear_inputs();
        set_lane(0, 8'h06, 7'd7, 7'd8);
        ctrlVerified_i = 1'b1; ctrlMispredict_i = 1'b0; ctrlCkpt_i = 3'd1;
        step();
        e = q.pop_front();
        n_checks++;
        if (rrValid_o !== 4'b0001 || rrValid_o !== e.valid) begin
            n_fail++; $display("FAIL verify_valid got=%b want=0001", rrValid_o);
        end
        n_checks++;
        if (rrPacket_o[MASK_LSB +: MASK_W] !== 8'h04 || rrPacket_o !== e.pkt) begin
            n_fail++; $display("FAIL verify_mask got=%h want=04", rrPacket_o[MASK_LSB +: MASK_W]);
        end
    endtask

    task automatic test_flush_hold();
        clear_inputs();
        for (int k = 0; k < IW; k++) begin
            set_lane(k, 8'h20 | 8'(1 << k), 7'(k + 10), 7'(k + 20));
            set_prf(k, $urandom, $urandom);
        end
        flush_i = 1'b1;
        step();
        e = q.pop_front();
        n_checks++;
        if (rrValid_o !== 4'h0 || rrValid_o !== e.valid) begin
            n_fail++; $display("FAIL flush_valid got=%h want=0", rrValid_o);
        end
        n_checks++;
        if (rrPacket_o !== e.pkt || rrOpA_o !== e.a || rrOpB_o !== e.b) begin
            n_fail++; $display("FAIL flush_payload got a=%h want a=%h", rrOpA_o, e.a);
        end
        // Idle cycle with junk on the input buses: everything must hold.
        clear_inputs();
        for (int k = 0; k < IW; k++) begin
            grantedPacket_i[k*PACKET_W +: PACKET_W] = mk_pkt(8'hFF, 7'd1, 7'd1);
            set_prf(k, $urandom, $urandom);
        end
        step();
        e = q.pop_front();
        n_checks++;
        if (rrValid_o !== 4'h0 || rrValid_o !== e.valid) begin
            n_fail++; $display("FAIL hold_valid got=%h want=0", rrValid_o);
        end
        n_checks++;
        if (rrPacket_o !== e.pkt || rrOpA_o !== e.a || rrOpB_o !== e.b) begin
            n_fail++; $display("FAIL hold_payload got a=%h want a=%h", rrOpA_o, e.a);
        end
        // Correct verify on checkpoint 5 clears that bit in every held mask.
        ctrlVerified_i = 1'b1; ctrlCkpt_i = 3'd5;
        step();
        e = q.pop_front();
        n_checks++;
        if (rrPacket_o[MASK_LSB +: MASK_W] !== 8'h01 || rrPacket_o !== e.pkt) begin
            n_fail++; $display("FAIL held_mask_clear got=%h want=01", rrPacket_o[MASK_LSB +: MASK_W]);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        for (int c = 0; c < 40; c++) begin
            clear_inputs();
            grantedValid_i = 4'($urandom);
            for (int k = 0; k < IW; k++) begin
                grantedPacket_i[k*PACKET_W +: PACKET_W] =
                    mk_pkt(8'($urandom), 7'($urandom_range(0, 9)), 7'($urandom_range(0, 9)));
                set_prf(k, $urandom, $urandom);
            end
            base = $urandom_range(0, 9);
            for (int p = 0; p < BYPASS_PORTS; p++)
                set_byp(p, 1'($urandom), 7'((base + p) % 10), $urandom);
            ctrlVerified_i   = ($urandom_range(0, 2) == 0);
            ctrlMispredict_i = 1'($urandom);
            ctrlCkpt_i       = 3'($urandom);
            flush_i          = ($urandom_range(0, 15) == 0);
            step();
            e = q.pop_front();
            n_checks++;
            if (rrValid_o !== e.valid) begin
                n_fail++; $display("FAIL b2b_valid cycle %0d got=%h want=%h", c, rrValid_o, e.valid);
            end
            n_checks++;
            if (rrPacket_o !== e.pkt) begin
                n_fail++; $display("FAIL b2b_packet cycle %0d differs from model", c);
            end
            n_checks++;
            if (rrOpA_o !== e.a) begin
                n_fail++; $display("FAIL b2b_opa cycle %0d got=%h want=%h", c, rrOpA_o, e.a);
            end
            n_checks++;
            if (rrOpB_o !== e.b) begin
                n_fail++; $display("FAIL b2b_opb cycle %0d got=%h want=%h", c, rrOpB_o, e.b);
            end
        end
    endtask

    initial begin
        clear_inputs();
        m = '0;
        test_reset();
        test_prf_path();
        test_bypass();
        test_mispredict();
        test_correct_verify();
        test_flush_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
